dm_wb_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and

---
 rtl/mem_pkg.sv | 34 +++
 rtl/dm_cache_array.sv | 62 ++++++
 rtl/dm_wb_cache.sv | 136 +++++++++++++
 tb/tb_dm_wb_cache.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memory-side block protocol types and cache geometry helpers
package mem_pkg;

  localparam int BLOCKSIZE      = 128;
  localparam int BYTE_ADDR_BITS = 4;
  localparam int CACHE_SETS     = 256;

  typedef struct packed {
    logic                 Valid;
    logic                 Wen;
    logic [31:0]          Addr;
    logic [BLOCKSIZE-1:0] WriteD;
  } CacheToMem_t;

  typedef struct packed {
    logic                 Ready;
    logic [BLOCKSIZE-1:0] ReadD;
  } MemToCache_t;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_e;

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int sets);
    return 32 - BYTE_ADDR_BITS - $clog2(sets);
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// rtl/dm_cache_array.sv - tag/valid/dirty/data storage, async read, sync line fill or byte-merged store
module dm_cache_array
  import mem_pkg::*;
#(
  parameter int SETS = CACHE_SETS,
  localparam int IW  = index_width(SETS),
  localparam int TW  = tag_width(SETS),
  localparam int WSW = $clog2(BLOCKSIZE / 32)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IW-1:0]        idx_i,
  output logic                 rd_valid_o,
  output logic                 rd_dirty_o,
  output logic [TW-1:0]        rd_tag_o,
  output logic [BLOCKSIZE-1:0] rd_data_o,
  input  logic                 fill_en_i,
  input  logic [TW-1:0]        fill_tag_i,
  input  logic [BLOCKSIZE-1:0] fill_data_i,
  input  logic                 store_en_i,
  input  logic [WSW-1:0]       store_word_i,
  input  logic [31:0]          store_wdata_i,
  input  logic [3:0]           store_be_i
);

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TW-1:0]        tag_q  [SETS];
  logic [BLOCKSIZE-1:0] data_q [SETS];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[idx_i];

  // Only the status bits are reset; tags and data are meaningless while valid is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (store_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (store_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be_i[b]) begin
          data_q[idx_i][32*store_word_i + 8*b +: 8] <= store_wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dm_wb_cache.sv
// rtl/dm_wb_cache.sv - direct-mapped write-back write-allocate data cache (option: CACHE_STATS_EN)
module dm_wb_cache
  import mem_pkg::*;
#(
  parameter int SETS = CACHE_SETS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_valid_i,
  input  logic        cpu_wen_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_be_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  output CacheToMem_t Mem_o,
  input  MemToCache_t Mem_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  localparam int IW  = index_width(SETS);
  localparam int TW  = tag_width(SETS);
  localparam int WSW = $clog2(BLOCKSIZE / 32);

  cache_state_e         state_q, state_d;
  logic                 first_q;
  logic                 rd_valid, rd_dirty, hit, accept, fill_en, store_en;
  logic [TW-1:0]        rd_tag;
  logic [BLOCKSIZE-1:0] rd_data;

  logic [IW-1:0]  req_idx;
  logic [TW-1:0]  req_tag;
  logic [WSW-1:0] req_word;
  logic           unused_addr_lsb;

  assign req_idx         = cpu_addr_i[BYTE_ADDR_BITS +: IW];
  assign req_tag         = cpu_addr_i[31 -: TW];
  assign req_word        = cpu_addr_i[BYTE_ADDR_BITS-1:2];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  dm_cache_array #(.SETS(SETS)) u_array (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .idx_i        (req_idx),
    .rd_valid_o   (rd_valid),
    .rd_dirty_o   (rd_dirty),
    .rd_tag_o     (rd_tag),
    .rd_data_o    (rd_data),
    .fill_en_i    (fill_en),
    .fill_tag_i   (req_tag),
    .fill_data_i  (Mem_i.ReadD),
    .store_en_i   (store_en),
    .store_word_i (req_word),
    .store_wdata_i(cpu_wdata_i),
    .store_be_i   (cpu_be_i)
  );

  assign hit         = rd_valid && (rd_tag == req_tag);
  // The first Ready seen in a memory state answers the previous request.
  assign accept      = Mem_i.Ready && !first_q;
  assign cpu_rdata_o = rd_data[32*req_word +: 32];
  assign store_en    = (state_q == COMPARE) && cpu_valid_i && cpu_wen_i && hit;
  assign fill_en     = (state_q == ALLOCATE) && accept;

  always_comb begin
    state_d      = state_q;
    cpu_ready_o  = 1'b0;
    Mem_o.Valid  = 1'b0;
    Mem_o.Wen    = 1'b0;
    Mem_o.Addr   = '0;
    Mem_o.WriteD = rd_data;
    case (state_q)
      COMPARE: begin
        if (cpu_valid_i) begin
          if (hit) begin
            cpu_ready_o = 1'b1;
          end else begin
            state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        Mem_o.Valid = 1'b1;
        Mem_o.Wen   = 1'b1;
        Mem_o.Addr  = {rd_tag, req_idx, {BYTE_ADDR_BITS{1'b0}}};
        if (accept) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        Mem_o.Valid = 1'b1;
        Mem_o.Addr  = {req_tag, req_idx, {BYTE_ADDR_BITS{1'b0}}};
        if (accept) state_d = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= COMPARE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;
  logic        retry_q;

  // retry_q marks a request that already missed, so its post-fill hit is not counted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      retry_q      <= 1'b0;
    end else if (state_q == COMPARE && cpu_valid_i) begin
      if (hit) begin
        if (!retry_q) hit_count_q <= hit_count_q + 32'd1;
        retry_q <= 1'b0;
      end else begin
        if (!retry_q) miss_count_q <= miss_count_q + 32'd1;
        retry_q <= 1'b1;
      end
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_dm_wb_cache.sv
// tb/tb_dm_wb_cache.sv - self-checking bench: coherent-memory reference model and 1-cycle memory responder
module tb_dm_wb_cache;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid, cpu_wen, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  CacheToMem_t mem_o;
  MemToCache_t mem_i;
  logic        mem_ready = 1'b0;
  logic [127:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_i = {mem_ready, mem_rdata};

  dm_wb_cache dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cpu_valid_i (cpu_valid),
    .cpu_wen_i   (cpu_wen),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_be_i    (cpu_be),
    .cpu_rdata_o (cpu_rdata),
    .cpu_ready_o (cpu_ready),
    .Mem_o       (mem_o),
    .Mem_i       (mem_i)
`ifdef CACHE_STATS_EN
    ,
    .hit_count_o (hit_count),
    .miss_count_o(miss_count)
`endif
  );

  // Backing memory (what the DUT wrote back) and the CPU-visible reference contents.
  logic [127:0] mem_blk [int unsigned];
  logic [127:0] ref_blk [int unsigned];
  bit           res_valid [256];
  bit           res_dirty [256];
  logic [19:0]  res_tag   [256];
  int           exp_hits, exp_misses;

  function automatic logic [127:0] init_blk(input int unsigned b);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = (b * 4 + i) * 32'h9E3779B1 + 32'h01234567;
    return v;
  endfunction

  function automatic logic [127:0] get_mem(input int unsigned b);
    return mem_blk.exists(b) ? mem_blk[b] : init_blk(b);
  endfunction

  function automatic logic [127:0] get_ref(input int unsigned b);
    return ref_blk.exists(b) ? ref_blk[b] : init_blk(b);
  endfunction

  // Memory answers one cycle after sampling Valid; write responses carry junk ReadD.
  always @(posedge clk) begin
    mem_ready <= mem_o.Valid;
    if (mem_o.Valid && mem_o.Wen) begin
      mem_blk[mem_o.Addr >> 4] = mem_o.WriteD;
      mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end else if (mem_o.Valid) begin
      mem_rdata <= get_mem(mem_o.Addr >> 4);
    end else begin
      mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic reset_model();
    ref_blk = mem_blk;
    for (int s = 0; s < 256; s++) begin
      res_valid[s] = 0;
      res_dirty[s] = 0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic predict(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] erd, output int elat);
    int unsigned  b;
    int           s, w;
    bit           h;
    logic [127:0] blk;
    s = int'(addr[11:4]);
    w = int'(addr[3:2]);
    b = addr >> 4;
    h = res_valid[s] && res_tag[s] == addr[31:12];
    elat = h ? 0 : ((res_valid[s] && res_dirty[s]) ? 5 : 3);
    if (h) exp_hits++; else exp_misses++;
    res_dirty[s] = h ? (res_dirty[s] | wen) : wen;
    res_valid[s] = 1;
    res_tag[s]   = addr[31:12];
    blk = get_ref(b);
    erd = blk[32*w +: 32];
    if (wen) for (int i = 0; i < 4; i++) if (be[i]) blk[32*w + 8*i +: 8] = wdata[8*i +: 8];
    ref_blk[b] = blk;
  endtask

  logic         wb_seen, al_seen;
  logic [31:0]  wb_addr, al_addr;
  logic [127:0] wb_data;

  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output int lat);
    cpu_valid = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    lat = -1; rdata = 'x; wb_seen = 0; al_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_o.Valid && mem_o.Wen && !wb_seen) begin
        wb_seen = 1; wb_addr = mem_o.Addr; wb_data = mem_o.WriteD;
      end
      if (mem_o.Valid && !mem_o.Wen && !al_seen) begin
        al_seen = 1; al_addr = mem_o.Addr;
      end
      if (cpu_ready) begin
        lat = c; rdata = cpu_rdata;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    checks++;
    if (mem_o.Valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_o.Valid); end
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cpu_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [31:0] rd, erd; int lat, elat;
    predict(0, 32'h0001_0000, 0, 0, erd, elat);
    do_req(0, 32'h0001_0000, 0, 0, rd, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL fill_latency: got %0d expected 3", lat); end
    checks++;
    if (!al_seen || al_addr !== 32'h0001_0000 || wb_seen)
      begin errors++; $display("FAIL fill_alloc_addr: got seen=%b addr=%h wb=%b expected 1 00010000 0", al_seen, al_addr, wb_seen); end
    checks++;
    if (rd !== erd) begin errors++; $display("FAIL fill_rdata: got %h expected %h", rd, erd); end
  endtask

  task automatic test_hit();
    logic [31:0] rd, erd; int lat, elat;
    predict(0, 32'h0001_0004, 0, 0, erd, elat);
    do_req(0, 32'h0001_0004, 0, 0, rd, lat);
    checks++;
    if (lat !== 0 || al_seen || wb_seen)
      begin errors++; $display("FAIL hit_no_mem: got lat=%0d memvalid=%b expected 0 0", lat, al_seen | wb_seen); end
    checks++;
    if (rd !== erd) begin errors++; $display("FAIL hit_rdata: got %h expected %h", rd, erd); end
  endtask

  task automatic test_writeback();
    logic [31:0] rd, erd; int lat, elat;
    predict(1, 32'h0001_0008, 32'hDEADBEEF, 4'hF, erd, elat);
    do_req(1, 32'h0001_0008, 32'hDEADBEEF, 4'hF, rd, lat);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL store_hit_latency: got %0d expected 0", lat); end
    predict(0, 32'h0001_1008, 0, 0, erd, elat);
    do_req(0, 32'h0001_1008, 0, 0, rd, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wb_latency: got %0d expected 5", lat); end
    checks++;
    if (!wb_seen || wb_addr !== 32'h0001_0000 || wb_data[95:64] !== 32'hDEADBEEF)
      begin errors++; $display("FAIL wb_request: got seen=%b addr=%h w2=%h expected 1 00010000 deadbeef", wb_seen, wb_addr, wb_data[95:64]); end
    checks++;
    if (!al_seen || al_addr !== 32'h0001_1000)
      begin errors++; $display("FAIL wb_alloc_addr: got %h expected 00011000", al_addr); end
    checks++;
    if (rd !== erd) begin errors++; $display("FAIL wb_fill_rdata: got %h expected %h", rd, erd); end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd, erd, old; int lat, elat;
    predict(0, 32'h0001_0004, 0, 0, erd, elat);
    do_req(0, 32'h0001_0004, 0, 0, rd, lat);
    old = erd;
    checks++;
    if (lat !== elat || rd !== erd) begin errors++; $display("FAIL bs_reload: got %0d/%h expected %0d/%h", lat, rd, elat, erd); end
    predict(1, 32'h0001_0004, 32'hAABBCCDD, 4'b0010, erd, elat);
    do_req(1, 32'h0001_0004, 32'hAABBCCDD, 4'b0010, rd, lat);
    predict(0, 32'h0001_0004, 0, 0, erd, elat);
    do_req(0, 32'h0001_0004, 0, 0, rd, lat);
    checks++;
    if (lat !== 0 || rd !== {old[31:16], 8'hCC, old[7:0]})
      begin errors++; $display("FAIL byte_merge: got %0d/%h expected 0/%h", lat, rd, {old[31:16], 8'hCC, old[7:0]}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; int lat, elat;
    predict(0, 32'h0004_0010, 0, 0, erd, elat);
    cpu_valid = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0004_0010; cpu_be = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b0; cpu_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    checks++;
    if (mem_o.Valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", mem_o.Valid); end
    @(posedge clk); #1;
    predict(0, 32'h0004_0010, 0, 0, erd, elat);
    do_req(0, 32'h0004_0010, 0, 0, rd, lat);
    checks++;
    if (lat !== 3 || rd !== erd) begin errors++; $display("FAIL midreset_refill: got %0d/%h expected 3/%h", lat, rd, erd); end
    predict(0, 32'h0001_0004, 0, 0, erd, elat);
    do_req(0, 32'h0001_0004, 0, 0, rd, lat);
    checks++;
    if (lat !== 3 || rd !== erd) begin errors++; $display("FAIL dirty_lost: got %0d/%h expected 3/%h", lat, rd, erd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wdata; logic [19:0] tags [4];
    logic wen; logic [3:0] be; int lat, elat;
    tags = '{20'h00010, 20'h00020, 20'hbfc00, 20'hbfc01};
    for (int n = 0; n < 400; n++) begin
      addr  = {tags[$urandom_range(3)], 8'($urandom_range(3)), 2'($urandom_range(3)), 2'b00};
      wen   = 1'($urandom_range(1));
      be    = 4'($urandom);
      wdata = $urandom;
      predict(wen, addr, wdata, be, erd, elat);
      do_req(wen, addr, wdata, be, rd, lat);
      checks++;
      if (lat !== elat) begin errors++; $display("FAIL rand_latency[%0d] %h: got %0d expected %0d", n, addr, lat, elat); end
      if (!wen) begin
        checks++;
        if (rd !== erd) begin errors++; $display("FAIL rand_rdata[%0d] %h: got %h expected %h", n, addr, rd, erd); end
      end
    end
  endtask

  task automatic test_stats();
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'(exp_hits)) begin errors++; $display("FAIL hit_count: got %0d expected %0d", hit_count, exp_hits); end
    checks++;
    if (miss_count !== 32'(exp_misses)) begin errors++; $display("FAIL miss_count: got %0d expected %0d", miss_count, exp_misses); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_wen = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    exp_hits = 0; exp_misses = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_fill();
    test_hit();
    test_writeback();
    test_byte_store();
    test_reset_mid();
    test_random();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
